// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - dual-slot pipeline hazard detection, stall/flush sequencing and perf counters
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rsc,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             br_taken,
    input  logic             ex_regwr,
    input  logic             ex_regwrc,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_regdest,
    input  logic [4:0]       ex_regdestc,
    input  logic             mem_memrd,
    input  logic [4:0]       mem_regdest,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

    state_t     state, state_nx, saved, saved_nx, eff;
    logic [1:0] bubbles, bubbles_nx;
    logic [1:0] need;
    logic       lu, cx_main, cx_comp, cm, taken, freeze;
    logic       stall_inc, flush_inc;

    // r0 is hardwired zero, so it never produces a dependency
    function automatic logic hit(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

    // dest feeds an operand of the control-flow instruction resolved in ID
    function automatic logic cf_hit(input logic [4:0] dest, input logic br, input logic jr,
                                    input logic [4:0] rs1, input logic [4:0] rsc);
        return (jr && hit(dest, rs1)) || (br && (hit(dest, rs1) || hit(dest, rsc)));
    endfunction

    // hazard terms and bubble demand
    always_comb begin
        lu      = ex_memrd && (hit(ex_regdest, id_rs1) || hit(ex_regdest, id_rs2) ||
                               hit(ex_regdest, id_rsc));
        cx_main = ex_regwr  && cf_hit(ex_regdest,  id_branch, id_jump, id_rs1, id_rsc);
        cx_comp = ex_regwrc && cf_hit(ex_regdestc, id_branch, id_jump, id_rs1, id_rsc);
        cm      = mem_memrd && cf_hit(mem_regdest, id_branch, id_jump, id_rs1, id_rsc);
        need    = 2'd0;
        if (cx_main && ex_memrd)
            need = 2'd2;
        else if (lu || cx_main || cx_comp || cm)
            need = 2'd1;
        taken   = id_jump || (id_branch && br_taken);
        freeze  = dmem_req && !dmem_ready;
        // MEM_WAIT only parks the interrupted state; behaviour follows the parked state
        eff     = (state == MEM_WAIT) ? saved : state;
    end

    // next state and pipeline controls; freeze beats bubble beats flush
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        state_nx   = eff;
        saved_nx   = saved;
        bubbles_nx = bubbles;
        stall_inc  = 1'b0;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nx   = RUN;
            saved_nx   = RUN;
            bubbles_nx = 2'd0;
        end else if (freeze) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            state_nx  = MEM_WAIT;
            saved_nx  = eff;
            stall_inc = 1'b1;
        end else if (eff == STALL) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            bubbles_nx = (bubbles == 2'd0) ? 2'd0 : bubbles - 2'd1;
            state_nx   = (bubbles <= 2'd1) ? RUN : STALL;
        end else if (need != 2'd0) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            bubbles_nx = need - 2'd1;
            state_nx   = (need == 2'd2) ? STALL : RUN;
        end else if (taken) begin
            ifid_flush = 1'b1;
        end
        flush_inc = ifid_flush && !rst;
    end

    // state, bubble count and saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            saved        <= RUN;
            bubbles      <= 2'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state   <= state_nx;
            saved   <= saved_nx;
            bubbles <= bubbles_nx;
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the dual-slot VLIW core: main slot plus compressed slot.
- Sits beside the operand-forwarding unit and detects the hazards that forwarding cannot cover:
  - load-use hazards;
  - branch/jump resolved in ID whose operand is not yet available;
  - data-memory wait.
- Drives PC/pipeline-register enables and flushes.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of stall_cycles and flush_count performance counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
id_rs1  input  5  ID main-slot source 1
id_rs2  input  5  ID main-slot source 2
id_rsc  input  5  ID compressed-slot source
id_branch  input  1  ID holds branch (operands rs1, rsc)
id_jump  input  1  ID holds register jump (operand rs1)
br_taken  input  1  ID branch resolved taken (valid when id_branch)
ex_regwr  input  1  EX main slot writes register
ex_regwrc  input  1  EX compressed slot writes register
ex_memrd  input  1  EX main slot is a load
ex_regdest  input  5  EX main-slot destination
ex_regdestc  input  5  EX compressed-slot destination
mem_memrd  input  1  MEM main slot is a load
mem_regdest  input  5  MEM main-slot destination
dmem_req  input  1  MEM stage has active data-memory access
dmem_ready  input  1  data memory completes access this cycle
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID (kill fetched instruction)
idex_en  output  1  ID/EX register enable
idex_flush  output  1  load bubble into ID/EX
exmem_en  output  1  EX/MEM and MEM/WB enable
stall_cycles  output  CNT_W  saturating count of stall and freeze cycles
flush_count  output  CNT_W  saturating count of control-flow flushes

Behaviour:
- Register r0 never creates a hazard; every match requires dest != 0.
- Output timing: outputs are combinational from state and current inputs. State, bubble counter and performance counters are registered.
- Reset (async, rst=1):
  - state = RUN, bubbles = 0, both counters = 0.
  - While rst is high: pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, ifid_flush=1, idex_flush=1.
- Hazard terms, evaluated in RUN:
  - LU: ex_memrd && ex_regdest matches any of id_rs1, id_rs2, id_rsc.
  - CX: (id_jump && EX dest matches id_rs1) or (id_branch && EX dest matches id_rs1 or id_rsc). EX dest means ex_regdest with ex_regwr, or ex_regdestc with ex_regwrc.
  - CM: (id_branch || id_jump) && mem_memrd && mem_regdest matches the control-flow operands.
  - need = 2 if CX and the EX producer is a load; otherwise 1 if LU, CX or CM; otherwise 0.
- States:
  - RUN:
    - need=0 → all enables 1, no flush.
    - need=0 and taken control flow (id_jump, or id_branch && br_taken) → ifid_flush=1 and flush_count increments.
    - need>0 → bubble cycle this cycle: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. bubbles ← need-1. Go to STALL if need=2, else stay in RUN so the hazard is re-evaluated next cycle.
  - STALL:
    - Same outputs as a bubble cycle; the control-flow flush is suppressed.
    - bubbles decrements each cycle; at 0 → RUN.
  - MEM_WAIT:
    - Entered from any state when dmem_req && !dmem_ready.
    - Freeze: pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, no flushes. State and bubbles are held.
    - On dmem_ready → return to the saved state.
- Priority: MEM_WAIT freeze > hazard bubble > taken-branch flush.
  - A taken branch with a pending hazard is resolved only after the stall, once operands are valid.
  - The freeze takes effect in the same cycle the condition appears.
- stall_cycles increments on every bubble or freeze cycle; flush_count increments on every ifid_flush outside reset. Both saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-freeze aborts the sequence: return to RUN with counters cleared.

Test Plan:
1. Load-use: ex_memrd=1, ex_regdest=5, id_rs2=5 → exactly one cycle with pc_en=0, idex_flush=1; next cycle all enables 1; stall_cycles=1.
2. Branch on load: id_branch=1, id_rsc=7, ex_memrd=1, ex_regwr=1, ex_regdest=7 → two consecutive bubble cycles, then RUN. br_taken=1 afterwards → ifid_flush=1 for one cycle; flush_count=1.
3. Jump on ALU result in compressed slot: id_jump=1, id_rs1=3, ex_regwrc=1, ex_regdestc=3 → one bubble, then ifid_flush=1.
4. r0: ex_memrd=1, ex_regdest=0, id_rs1=0 → no stall; stall_cycles stays 0.
5. Memory wait during STALL: dmem_req=1, dmem_ready=0 for 3 cycles → all enables 0 for 3 cycles, bubbles held; after ready the remaining bubble completes; stall_cycles incremented by 3 plus bubbles.
6. Counter saturation / reset: preload to force stall_cycles to 0xFFFF, stall again → stays 0xFFFF. Assert rst mid-STALL → immediate RUN, counters 0, outputs at reset values.
